// File: rtl/spart_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// spart_pkg : register map, FSM state types and reset divisor for spart_ctrl
// Revision  : 1.0
// -----------------------------------------------------------------------------
package spart_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'b00,
    ADDR_STATUS  = 2'b01,
    ADDR_DB_LOW  = 2'b10,
    ADDR_DB_HIGH = 2'b11
  } ioaddr_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_CLR  = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'b00,
    TX_LOAD = 2'b01,
    TX_BUSY = 2'b10
  } tx_state_t;

  // 50 MHz clock, 9600 baud
  localparam logic [15:0] DEFAULT_DIV = 16'h1458;

endpackage
`default_nettype wire

// File: rtl/spart_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// spart_fifo : 8-bit circular byte queue with occupancy count
// Revision   : 1.0
// -----------------------------------------------------------------------------
module spart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [3:0] count,
  output logic       full,
  output logic       empty
);

  localparam int              c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw-1:0] c_last = c_aw'(DEPTH - 1);

  logic [7:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [3:0]      r_count;
  logic            w_push;
  logic            w_pop;

  assign full  = (r_count == 4'(DEPTH));
  assign empty = (r_count == 4'd0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // a pop in the same cycle frees the slot a push into a full queue needs
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spart_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// spart_ctrl : SPART bus-side controller - register decode, baud divisor,
//              RX drain and TX frame sequencing through two byte queues
// Revision   : 1.0
// -----------------------------------------------------------------------------
module spart_ctrl #(
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iocs_n,
  input  logic        iorw_n,
  input  logic [1:0]  ioaddr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic [15:0] baud_rate
);

  import spart_pkg::*;

  rx_state_t   r_rx_state;
  tx_state_t   r_tx_state;
  logic [15:0] r_baud;
  logic [7:0]  r_db_low;
  logic        r_clr_rdy;
  logic        r_trmt;
  logic [7:0]  r_tx_data;

  logic       w_rd_data, w_wr_data, w_wr_db_low, w_wr_db_high;
  logic       w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [7:0] w_rx_head, w_tx_head;
  logic [3:0] w_rx_count, w_tx_count, w_tx_free;

  assign w_rd_data    = !iocs_n &&  iorw_n && (ioaddr == ADDR_DATA);
  assign w_wr_data    = !iocs_n && !iorw_n && (ioaddr == ADDR_DATA);
  assign w_wr_db_low  = !iocs_n && !iorw_n && (ioaddr == ADDR_DB_LOW);
  assign w_wr_db_high = !iocs_n && !iorw_n && (ioaddr == ADDR_DB_HIGH);

  assign w_rx_pop  = w_rd_data && !w_rx_empty;
  assign w_rx_push = (r_rx_state == RX_IDLE) && rx_rdy && (!w_rx_full || w_rx_pop);
  assign w_tx_pop  = (r_tx_state == TX_IDLE) && !w_tx_empty;
  assign w_tx_push = w_wr_data && (!w_tx_full || w_tx_pop);
  assign w_tx_free = 4'(DEPTH) - w_tx_count;

  spart_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(w_rx_push), .pop(w_rx_pop), .din(rx_data),
    .dout(w_rx_head), .count(w_rx_count), .full(w_rx_full), .empty(w_rx_empty)
  );

  spart_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(w_tx_push), .pop(w_tx_pop), .din(wdata),
    .dout(w_tx_head), .count(w_tx_count), .full(w_tx_full), .empty(w_tx_empty)
  );

  always_comb begin
    rdata = 8'h00;
    case (ioaddr)
      ADDR_DATA:    rdata = w_rx_empty ? 8'h00 : w_rx_head;
      ADDR_STATUS:  rdata = {w_tx_free, w_rx_count};
      ADDR_DB_LOW:  rdata = r_baud[7:0];
      ADDR_DB_HIGH: rdata = r_baud[15:8];
      default:      rdata = 8'h00;
    endcase
  end

  // low byte is staged so the divisor never holds a half-written value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_low <= 8'h00;
      r_baud   <= DEFAULT_DIV;
    end else begin
      if (w_wr_db_low)  r_db_low <= wdata;
      if (w_wr_db_high) r_baud   <= {wdata, r_db_low};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_clr_rdy  <= 1'b0;
    end else begin
      r_clr_rdy <= 1'b0;
      case (r_rx_state)
        RX_IDLE: if (w_rx_push) begin
          r_clr_rdy  <= 1'b1;
          r_rx_state <= RX_CLR;
        end
        RX_CLR:  r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_trmt     <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_trmt <= 1'b0;
      case (r_tx_state)
        TX_IDLE: if (w_tx_pop) begin
          r_tx_data  <= w_tx_head;
          r_trmt     <= 1'b1;
          r_tx_state <= TX_LOAD;
        end
        TX_LOAD: r_tx_state <= TX_BUSY;
        TX_BUSY: if (tx_done) r_tx_state <= TX_IDLE;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign clr_rdy   = r_clr_rdy;
  assign trmt      = r_trmt;
  assign tx_data   = r_tx_data;
  assign baud_rate = r_baud;

endmodule
`default_nettype wire

// File: tb/tb_spart_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_spart_ctrl : queue-level reference model plus directed and random traffic
// Revision      : 1.0
// -----------------------------------------------------------------------------
module tb_spart_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iocs_n = 1'b1;
  logic        iorw_n = 1'b1;
  logic [1:0]  ioaddr = 2'd0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rdy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b1;
  logic [15:0] baud_rate;

  spart_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .iocs_n(iocs_n), .iorw_n(iorw_n), .ioaddr(ioaddr),
    .wdata(wdata), .rdata(rdata), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rdy(clr_rdy), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .baud_rate(baud_rate)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: queues, committed/staged divisor, expected output values
  logic [7:0]  m_rxq[$];
  logic [7:0]  m_txq[$];
  logic [15:0] m_baud;
  logic [7:0]  m_stage;
  logic [7:0]  m_txd;
  logic        m_clr;
  logic        m_trmt;
  int          m_phase;   // 0 no frame, 1 start pulse, 2 waiting for done
  bit          checks_on = 1'b0;

  // peripheral emulation state
  bit          drop_pend = 1'b0;
  bit          start_pend = 1'b0;
  bit          hold_done = 1'b0;
  int          frame_cnt = 0;
  int          frame_len = 20;
  int          clr_cnt = 0;
  int          trmt_cnt = 0;
  logic [7:0]  tx_seen[$];

  task automatic m_reset();
    m_rxq.delete();
    m_txq.delete();
    m_baud  = 16'h1458;
    m_stage = 8'h00;
    m_txd   = 8'h00;
    m_clr   = 1'b0;
    m_trmt  = 1'b0;
    m_phase = 0;
  endtask

  function automatic logic [7:0] exp_rdata();
    case (ioaddr)
      2'd0:    return (m_rxq.size() > 0) ? m_rxq[0] : 8'h00;
      2'd1:    return {4'(DEPTH - m_txq.size()), 4'(m_rxq.size())};
      2'd2:    return m_baud[7:0];
      default: return m_baud[15:8];
    endcase
  endfunction

  // advance the model across the coming rising edge using the inputs now stable
  task automatic m_step();
    bit rd, wr, cpu_pop, rx_take, tx_take, tx_acc;
    rd      = !iocs_n && iorw_n;
    wr      = !iocs_n && !iorw_n;
    cpu_pop = rd && (ioaddr == 2'd0) && (m_rxq.size() > 0);
    rx_take = !m_clr && rx_rdy && ((m_rxq.size() - int'(cpu_pop)) < DEPTH);
    tx_take = (m_phase == 0) && (m_txq.size() > 0);
    tx_acc  = wr && (ioaddr == 2'd0) && ((m_txq.size() - int'(tx_take)) < DEPTH);
    if (cpu_pop) void'(m_rxq.pop_front());
    if (rx_take) m_rxq.push_back(rx_data);
    m_clr = rx_take;
    if (tx_take) m_txd = m_txq.pop_front();
    if (tx_acc)  m_txq.push_back(wdata);
    m_trmt = tx_take;
    if (tx_take)                        m_phase = 1;
    else if (m_phase == 1)              m_phase = 2;
    else if (m_phase == 2 && tx_done)   m_phase = 0;
    if (wr && ioaddr == 2'd3) m_baud  = {wdata, m_stage};
    if (wr && ioaddr == 2'd2) m_stage = wdata;
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) m_reset();
    if (checks_on) begin
      chk("rdata",     16'(rdata),   16'(exp_rdata()));
      chk("clr_rdy",   16'(clr_rdy), 16'(m_clr));
      chk("trmt",      16'(trmt),    16'(m_trmt));
      chk("tx_data",   16'(tx_data), 16'(m_txd));
      chk("baud_rate", baud_rate,    m_baud);
    end
    if (clr_rdy) begin
      drop_pend = 1'b1;
      clr_cnt++;
    end
    if (trmt) begin
      start_pend = 1'b1;
      trmt_cnt++;
      tx_seen.push_back(tx_data);
      chk("trmt_while_busy", 16'(tx_done), 16'd1);
    end
    if (rst_n) m_step();
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (drop_pend) begin
      rx_rdy    = 1'b0;
      drop_pend = 1'b0;
    end
    if (start_pend) begin
      tx_done    = 1'b0;
      frame_cnt  = frame_len;
      start_pend = 1'b0;
    end else if (frame_cnt > 0) begin
      frame_cnt--;
      if (frame_cnt == 0 && !hold_done) tx_done = 1'b1;
    end else if (!hold_done && !tx_done) begin
      tx_done = 1'b1;
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    iocs_n = 1'b0;
    iorw_n = 1'b1;
    ioaddr = a;
    #1 v = rdata;
    step();
    iocs_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    iocs_n = 1'b0;
    iorw_n = 1'b0;
    ioaddr = a;
    wdata  = d;
    step();
    iocs_n = 1'b1;
  endtask

  task automatic clear_emu();
    drop_pend  = 1'b0;
    start_pend = 1'b0;
    frame_cnt  = 0;
    hold_done  = 1'b0;
    tx_done    = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    int c0, t0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    checks_on = 1'b1;

    // reset values
    rd(2'd1, v);
    chk("reset_status", 16'(v), 16'h0080);
    chk("reset_baud", baud_rate, 16'h1458);
    chk("reset_clr_rdy", 16'(clr_rdy), 16'd0);
    chk("reset_trmt", 16'(trmt), 16'd0);
    chk("reset_tx_data", 16'(tx_data), 16'd0);

    // staged divisor
    wr(2'd2, 8'h1B);
    rd(2'd2, v);
    chk("db_low_uncommitted", 16'(v), 16'h0058);
    wr(2'd3, 8'h01);
    #1 chk("baud_commit", baud_rate, 16'h011B);
    rd(2'd2, v);
    chk("db_low_committed", 16'(v), 16'h001B);

    // single RX byte
    c0 = clr_cnt;
    rx_data = 8'hA5;
    rx_rdy  = 1'b1;
    repeat (6) step();
    chk("rx_one_clr", 16'(clr_cnt - c0), 16'd1);
    chk("rx_rdy_dropped", 16'(rx_rdy), 16'd0);
    rd(2'd1, v); chk("rx_status_1", 16'(v), 16'h0081);
    rd(2'd0, v); chk("rx_data_a5", 16'(v), 16'h00A5);
    rd(2'd1, v); chk("rx_status_0", 16'(v), 16'h0080);
    rd(2'd0, v); chk("rx_empty_read", 16'(v), 16'h0000);

    // three TX frames, 20 cycles each
    frame_len = 20;
    tx_seen.delete();
    wr(2'd0, 8'h11);
    wr(2'd0, 8'h22);
    #1;
    chk("trmt_latency", 16'(trmt), 16'd1);
    chk("tx_data_first", 16'(tx_data), 16'h0011);
    wr(2'd0, 8'h33);
    for (int k = 0; k < 200 && tx_seen.size() < 3; k++) step();
    chk("tx_frames", 16'(tx_seen.size()), 16'd3);
    if (tx_seen.size() >= 3) begin
      chk("tx_order_0", 16'(tx_seen[0]), 16'h0011);
      chk("tx_order_1", 16'(tx_seen[1]), 16'h0022);
      chk("tx_order_2", 16'(tx_seen[2]), 16'h0033);
    end
    repeat (30) step();

    // fill RX, then a ninth byte held off until a read frees space
    for (int i = 0; i < DEPTH; i++) begin
      rx_data = 8'(8'h80 + i);
      rx_rdy  = 1'b1;
      for (int k = 0; k < 10 && rx_rdy; k++) step();
      step();
    end
    rd(2'd1, v); chk("rx_full_status", 16'(v), 16'h0088);
    c0 = clr_cnt;
    rx_data = 8'hC9;
    rx_rdy  = 1'b1;
    repeat (4) step();
    chk("rx_full_no_clr", 16'(clr_cnt - c0), 16'd0);
    chk("rx_full_rdy_held", 16'(rx_rdy), 16'd1);
    rd(2'd0, v); chk("rx_full_head", 16'(v), 16'h0080);
    step();
    step();
    chk("rx_ninth_clr", 16'(clr_cnt - c0), 16'd1);
    chk("rx_ninth_rdy", 16'(rx_rdy), 16'd0);
    rd(2'd1, v); chk("rx_still_full", 16'(v), 16'h0088);
    for (int i = 1; i <= 3; i++) begin
      rd(2'd0, v);
      chk("rx_drain", 16'(v), 16'(8'h80 + i));
    end

    // TX queue overflow while a frame is stuck busy
    hold_done = 1'b1;
    wr(2'd0, 8'h44);
    repeat (4) step();
    for (int i = 0; i < 9; i++) wr(2'd0, 8'(8'h50 + i));
    rd(2'd1, v); chk("tx_full_status", 16'(v), 16'h0005);
    t0 = trmt_cnt;
    repeat (5) step();
    chk("no_trmt_while_busy", 16'(trmt_cnt - t0), 16'd0);

    // asynchronous reset mid-frame
    #1 rst_n = 1'b0;
    #1;
    chk("arst_baud", baud_rate, 16'h1458);
    chk("arst_trmt", 16'(trmt), 16'd0);
    chk("arst_clr", 16'(clr_rdy), 16'd0);
    chk("arst_tx_data", 16'(tx_data), 16'd0);
    chk("arst_status", 16'(rdata), 16'h0080);
    clear_emu();
    repeat (2) step();
    rst_n = 1'b1;
    c0 = clr_cnt;
    t0 = trmt_cnt;
    repeat (20) step();
    chk("post_rst_clr", 16'(clr_cnt - c0), 16'd0);
    chk("post_rst_trmt", 16'(trmt_cnt - t0), 16'd0);
    rd(2'd1, v); chk("post_rst_status", 16'(v), 16'h0080);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 4) begin
        iocs_n = 1'b0;
        iorw_n = 1'($urandom_range(0, 1));
        ioaddr = 2'($urandom_range(0, 3));
        wdata  = 8'($urandom);
      end else begin
        iocs_n = 1'b1;
      end
      if (!rx_rdy && $urandom_range(0, 5) == 0) begin
        rx_rdy  = 1'b1;
        rx_data = 8'($urandom);
      end
      frame_len = int'($urandom_range(2, 12));
      if (n == 1500) begin
        rst_n = 1'b0;
        clear_emu();
      end
      if (n == 1503) rst_n = 1'b1;
      step();
    end
    iocs_n = 1'b1;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/spart_ctrl.md
Name: spart_ctrl

Overview:
Bus-side controller for the SPART serial core. It decodes processor I/O accesses to four registers and programs the 16-bit baud divisor shared by the receiver and transmitter. It drains received bytes from the receiver into an RX queue, using the receiver's ready/clear handshake. It also sequences queued TX bytes into the transmitter one frame at a time.

Parameters:
DEPTH, 8, entries in each of the RX and TX queues; must be a power of 2, maximum 8.
DEFAULT_DIV, 16'h1458, baud divisor after reset (50 MHz clock, 9600 baud).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
iocs_n  in  1  chip select, active low; each clk cycle it is low is one access
iorw_n  in  1  1 = read, 0 = write
ioaddr  in  2  register address: 00 DATA, 01 STATUS, 10 DB_LOW, 11 DB_HIGH
wdata  in  8  write data
rdata  out  8  read data, combinational from ioaddr and queue state
rx_rdy  in  1  receiver byte-ready level
rx_data  in  8  receiver byte
clr_rdy  out  1  one-cycle pulse that clears rx_rdy
trmt  out  1  one-cycle transmit-start pulse
tx_data  out  8  byte presented to the transmitter, registered
tx_done  in  1  transmitter idle/done level; must drop on the edge that samples trmt
baud_rate  out  16  divisor driven to both receiver and transmitter

Behaviour:
- Reset values: rdata reflects empty queues; clr_rdy=0; trmt=0; tx_data=0; baud_rate=DEFAULT_DIV; both queues empty; staged low byte=8'h00; both FSMs in IDLE.
- Write DATA: push wdata into the TX queue. If the TX queue is full, the write is silently dropped.
- Read DATA: rdata = RX queue head. The pop happens on the clock edge of that access cycle. If the RX queue is empty, rdata=8'h00 and no pop occurs.
- Read STATUS: rdata = {tx_free[3:0], rx_count[3:0]}. Reset value is {DEPTH, 0}. Writes to STATUS are ignored.
- Write DB_LOW: stores the staged low byte only; baud_rate is unchanged.
- Write DB_HIGH: baud_rate <= {wdata, staged_low} atomically on that edge.
- Read DB_LOW / DB_HIGH: returns baud_rate[7:0] / baud_rate[15:8] (the committed value, not the staged byte).
- Queues: circular buffers with wrap-around pointers and a count of 0..DEPTH. A push and a pop in the same cycle are both performed and the count is unchanged. A pop from an empty queue or a push to a full queue is a no-op.
- RX FSM:
  - IDLE: if rx_rdy and the RX queue is not full, push rx_data, pulse clr_rdy, and go to CLR.
  - IDLE: if rx_rdy and the queue is full, hold with no clr_rdy. The receiver keeps the byte until space frees. A byte is lost only if a new frame overwrites it; that is accepted behaviour.
  - CLR: wait one cycle for rx_rdy to fall, then return to IDLE. A byte is never captured twice.
  - A CPU pop and an RX push in the same cycle on a full queue: the push proceeds because the pop frees space that cycle.
- TX FSM:
  - IDLE: if the TX queue is non-empty, pop the head into tx_data, then go to LOAD.
  - LOAD: trmt=1 for exactly one cycle, then go to BUSY.
  - BUSY: wait for tx_done=1, then go to IDLE. Back-to-back frames are separated by at least 2 idle cycles.
  - Latency from a DATA write to trmt: 2 cycles when the FSM is idle.
- A baud_rate change mid-frame takes effect immediately. Software must drain TX and idle RX before changing it.
- An rst_n assertion mid-operation asynchronously returns everything to reset values. Queue contents are discarded; any frame in flight is abandoned.

Decomposition:
- Package spart_pkg holds:
  - the ioaddr enum (DATA, STATUS, DB_LOW, DB_HIGH),
  - rx_state_t {IDLE, CLR},
  - tx_state_t {IDLE, LOAD, BUSY},
  - the DEFAULT_DIV constant.
- One sub-module, spart_fifo (parameter DEPTH, 8 bits wide; ports push, pop, din, dout, count, full, empty), is instantiated twice: RX and TX.

Test Plan:
- Reset → baud_rate=16'h1458; STATUS reads 8'h80; clr_rdy, trmt and tx_data are all 0.
- Write DB_LOW=8'h1B, read DB_LOW → 8'h58 (not yet committed). Then write DB_HIGH=8'h01 → baud_rate=16'h011B on that edge; DB_LOW now reads 8'h1B.
- Raise rx_rdy with rx_data=8'hA5, dropping rx_rdy on clr_rdy → exactly one clr_rdy pulse; STATUS=8'h81; read DATA → 8'hA5; STATUS=8'h80; next DATA read → 8'h00.
- Write 8'h11, 8'h22, 8'h33 to DATA with tx_done modelled at 20 cycles per frame → three trmt pulses with tx_data 11, 22, 33 in order, none issued while tx_done=0. Write 9 bytes back-to-back with tx_done held 0 → the 9th is dropped and tx_free reads 0.
- Fill the RX queue to 8, then present a 9th byte → no clr_rdy and rx_rdy held. Read DATA once → the 9th byte is captured in the same cycle and the count stays 8.
- Assert rst_n mid-BUSY with both queues partially full → immediate return to reset values, with no trmt or clr_rdy after release.
